// File: rtl/ama_riscv_bp_pkg.sv
// Shared types and helpers for the gshare branch-predictor controller.
package ama_riscv_bp_pkg;

   localparam int unsigned BP_IDX_BITS = 5;
   localparam int unsigned BP_CNT_BITS = 2;

   typedef logic [BP_IDX_BITS-1:0] bp_idx_t;
   typedef logic [BP_CNT_BITS-1:0] bp_cnt_t;

   typedef struct packed {
      bp_idx_t idx;
      bp_idx_t ghr;
      logic    pred;
   } bp_q_entry_t;

   function automatic bp_cnt_t sat_cnt(input bp_cnt_t cnt, input logic taken);
      bp_cnt_t r;
      if (taken) r = (cnt == '1) ? cnt : cnt + bp_cnt_t'(1);
      else       r = (cnt == '0) ? cnt : cnt - bp_cnt_t'(1);
      return r;
   endfunction

endpackage

// File: rtl/ama_riscv_bp_queue.sv
// In-order queue of in-flight predictions; clear has priority over push/pop.
module ama_riscv_bp_queue
   import ama_riscv_bp_pkg::*;
#(
   parameter int unsigned Q_DEPTH = 4,
   localparam int unsigned PW = $clog2(Q_DEPTH),
   localparam int unsigned CW = PW + 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  bp_q_entry_t   push_data_i,
   input  logic          pop_i,
   input  logic          clear_i,
   output bp_q_entry_t   head_o,
   output bp_idx_t       next_ghr_o,
   output logic [CW-1:0] count_o
);

   bp_q_entry_t   mem_q [Q_DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt_q == CW'(Q_DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         if (do_pop)  rd_d = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

   assign head_o     = mem_q[rd_q];
   assign next_ghr_o = mem_q[rd_q + PW'(1)].ghr;
   assign count_o    = cnt_q;

endmodule

// File: rtl/ama_riscv_bp_ctrl.sv
// Gshare predictor controller: fetch-side PHT indexing/prediction, resolve-side
// training, mispredict detection and global-history repair.
module ama_riscv_bp_ctrl
   import ama_riscv_bp_pkg::*;
#(
   parameter int unsigned IDX_BITS = BP_IDX_BITS,
   parameter int unsigned CNT_BITS = BP_CNT_BITS,
   parameter int unsigned Q_DEPTH  = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                pred_req,
   input  logic [IDX_BITS-1:0] pc_idx,
   output logic                pred_ready,
   output logic                pred_taken,
   output logic [IDX_BITS-1:0] pht_idx,
   input  logic [CNT_BITS-1:0] pht_read,
   input  logic                res_valid,
   input  logic                res_taken,
   input  logic                flush,
   output logic [IDX_BITS-1:0] pht_idx_up,
   input  logic [CNT_BITS-1:0] pht_read_up,
   output logic [CNT_BITS-1:0] pht_update_val,
   output logic                pht_update_en,
   output logic                mispredict,
   output logic                res_err
);

   localparam int unsigned CW = $clog2(Q_DEPTH) + 1;

   if (IDX_BITS != BP_IDX_BITS || CNT_BITS != BP_CNT_BITS) begin : g_cfg_width_err
      $error("ama_riscv_bp_ctrl: IDX_BITS/CNT_BITS must match ama_riscv_bp_pkg");
   end
   if (Q_DEPTH < 2 || (Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_cfg_depth_err
      $error("ama_riscv_bp_ctrl: Q_DEPTH must be a power of two >= 2");
   end

   logic [IDX_BITS-1:0] ghr_q, ghr_d;
   logic                upd_en_q;
   logic [IDX_BITS-1:0] upd_idx_q;
   logic                upd_taken_q;
   logic                mis_q;
   logic                err_q;

   bp_q_entry_t         q_head;
   bp_q_entry_t         push_entry;
   bp_idx_t             q_next_ghr;
   logic [CW-1:0]       q_count;
   logic                q_nempty;
   logic                fire;
   logic                pop;
   logic                mis;
   logic                q_push;
   logic                q_clear;
   logic                unused_pht_bits;

   assign pht_idx    = pc_idx ^ ghr_q;
   assign pred_taken = pht_read[CNT_BITS-1];
   assign pred_ready = (q_count != CW'(Q_DEPTH));

   assign q_nempty = (q_count != '0);
   assign fire     = pred_req && pred_ready;
   assign pop      = res_valid && q_nempty;
   assign mis      = pop && (res_taken != q_head.pred);
   assign q_push   = fire && !mis && !flush;
   assign q_clear  = mis || flush;

   assign push_entry.idx  = pht_idx;
   assign push_entry.ghr  = ghr_q;
   assign push_entry.pred = pred_taken;

   // On flush with a same-cycle pop, history restores from the entry behind the head.
   always_comb begin
      ghr_d = ghr_q;
      if (mis) begin
         ghr_d = {q_head.ghr[IDX_BITS-2:0], res_taken};
      end else if (flush) begin
         if (pop) begin
            if (q_count > CW'(1)) ghr_d = q_next_ghr;
         end else if (q_nempty) begin
            ghr_d = q_head.ghr;
         end
      end else if (fire) begin
         ghr_d = {ghr_q[IDX_BITS-2:0], pred_taken};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q       <= '0;
         upd_en_q    <= 1'b0;
         upd_idx_q   <= '0;
         upd_taken_q <= 1'b0;
         mis_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         ghr_q    <= ghr_d;
         upd_en_q <= pop;
         if (pop) begin
            upd_idx_q   <= q_head.idx;
            upd_taken_q <= res_taken;
         end
         mis_q <= mis;
         if (res_valid && !q_nempty) err_q <= 1'b1;
      end
   end

   ama_riscv_bp_queue #(
      .Q_DEPTH (Q_DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (q_push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .clear_i     (q_clear),
      .head_o      (q_head),
      .next_ghr_o  (q_next_ghr),
      .count_o     (q_count)
   );

   assign pht_idx_up     = upd_idx_q;
   assign pht_update_en  = upd_en_q;
   assign pht_update_val = upd_en_q ? sat_cnt(pht_read_up, upd_taken_q) : '0;
   assign mispredict     = mis_q;
   assign res_err        = err_q;

   assign unused_pht_bits = ^pht_read[CNT_BITS-2:0];

endmodule

// File: tb/tb_ama_riscv_bp_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, randomized model compare.
module tb_ama_riscv_bp_ctrl;

   localparam int IB = 5;
   localparam int CB = 2;
   localparam int QD = 4;
   localparam int CMAX = (1 << CB) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          pred_req;
   logic [IB-1:0] pc_idx;
   logic          pred_ready;
   logic          pred_taken;
   logic [IB-1:0] pht_idx;
   logic [CB-1:0] pht_read;
   logic          res_valid;
   logic          res_taken;
   logic          flush;
   logic [IB-1:0] pht_idx_up;
   logic [CB-1:0] pht_read_up;
   logic [CB-1:0] pht_update_val;
   logic          pht_update_en;
   logic          mispredict;
   logic          res_err;

   always #5 clk = ~clk;

   ama_riscv_bp_ctrl #(
      .IDX_BITS (IB),
      .CNT_BITS (CB),
      .Q_DEPTH  (QD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pred_req       (pred_req),
      .pc_idx         (pc_idx),
      .pred_ready     (pred_ready),
      .pred_taken     (pred_taken),
      .pht_idx        (pht_idx),
      .pht_read       (pht_read),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .flush          (flush),
      .pht_idx_up     (pht_idx_up),
      .pht_read_up    (pht_read_up),
      .pht_update_val (pht_update_val),
      .pht_update_en  (pht_update_en),
      .mispredict     (mispredict),
      .res_err        (res_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          rst, req, rv, rt, fl;
      bit [IB-1:0] pc;
      bit [CB-1:0] rd, rdup;
      bit [IB-1:0] e_idx, e_idxup;
      bit          e_pt, e_rdy, e_en, e_mis, e_err;
      bit [CB-1:0] e_val;
   } vec_t;

   function automatic vec_t mk(int r, int rq, int pc, int rd, int rv, int rt, int fl, int rdup,
                               int eidx, int ept, int erdy, int een, int eiu, int eval,
                               int emis, int eerr);
      vec_t v;
      v.rst = 1'(r); v.req = 1'(rq); v.pc = IB'(pc); v.rd = CB'(rd);
      v.rv = 1'(rv); v.rt = 1'(rt); v.fl = 1'(fl); v.rdup = CB'(rdup);
      v.e_idx = IB'(eidx); v.e_pt = 1'(ept); v.e_rdy = 1'(erdy); v.e_en = 1'(een);
      v.e_idxup = IB'(eiu); v.e_val = CB'(eval); v.e_mis = 1'(emis); v.e_err = 1'(eerr);
      return v;
   endfunction

   task automatic drive_idle();
      pred_req = 0; pc_idx = '0; pht_read = '0; res_valid = 0;
      res_taken = 0; flush = 0; pht_read_up = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Reference model state
   typedef struct { bit [IB-1:0] idx; bit [IB-1:0] ghr; bit pred; } ment_t;
   ment_t       mq[$];
   bit [IB-1:0] m_ghr;
   bit [CB-1:0] pht[1 << IB];
   bit          m_upd, m_upd_t, m_mis, m_err;
   bit [IB-1:0] m_upd_idx;

   function automatic int sat_ref(int v, bit taken);
      int r;
      r = taken ? v + 1 : v - 1;
      if (r > CMAX) r = CMAX;
      if (r < 0) r = 0;
      return r;
   endfunction

   vec_t tbl[$];

   initial begin
      do_reset();

      // predict / train
      tbl.push_back(mk(0,0,'h0A,2,0,0,0,0, 'h0A,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h0A,2,0,0,0,0, 'h0A,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,1,1,0,0, 'h01,0,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,2, 'h01,0,1,1,'h0A,3,0,0));
      // saturation at both ends
      tbl.push_back(mk(0,1,'h03,3,0,0,0,0, 'h02,1,1,0,'h0A,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,1,1,0,0, 'h03,0,1,0,'h0A,0,0,0));
      tbl.push_back(mk(0,1,'h00,0,0,0,0,3, 'h03,0,1,1,'h02,3,0,0));
      tbl.push_back(mk(0,0,'h00,0,1,0,0,0, 'h06,0,1,0,'h02,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,0, 'h06,0,1,1,'h03,0,0,0));
      // reset, then mispredict repair
      tbl.push_back(mk(1,0,'h0A,2,0,0,0,0, 'h0A,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,0,0,0,0, 'h00,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,3,0,0,0,0, 'h01,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,0,0,0,0, 'h03,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,1,0,0,0, 'h07,0,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,2, 'h00,0,1,1,'h00,1,1,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,0, 'h00,0,1,0,'h00,0,0,0));
      // full / stall
      tbl.push_back(mk(0,1,'h00,2,0,0,0,0, 'h00,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,0,0,0,0, 'h01,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,0,0,0,0, 'h03,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,0,0,0,0, 'h07,1,1,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,1,1,0,0, 'h0F,1,0,0,'h00,0,0,0));
      tbl.push_back(mk(0,1,'h00,2,0,0,0,1, 'h0F,1,1,1,'h00,2,0,0));
      tbl.push_back(mk(0,0,'h00,0,1,1,0,0, 'h1F,0,0,0,'h00,0,0,0));
      // flush with two pending, then resolve on empty
      tbl.push_back(mk(0,0,'h00,0,1,1,0,0, 'h1F,0,1,1,'h01,1,0,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,1,3, 'h1F,0,1,1,'h03,3,0,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,0, 'h07,0,1,0,'h03,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,1,1,0,0, 'h07,0,1,0,'h03,0,0,0));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,0, 'h07,0,1,0,'h03,0,0,1));
      tbl.push_back(mk(0,0,'h00,0,0,0,0,0, 'h07,0,1,0,'h03,0,0,1));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; pred_req = tbl[i].req; pc_idx = tbl[i].pc;
         pht_read = tbl[i].rd; res_valid = tbl[i].rv; res_taken = tbl[i].rt;
         flush = tbl[i].fl; pht_read_up = tbl[i].rdup;
         #3;
         chk($sformatf("v%0d pht_idx", i), 32'(pht_idx), 32'(tbl[i].e_idx));
         chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(tbl[i].e_pt));
         chk($sformatf("v%0d pred_ready", i), 32'(pred_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d upd_en", i), 32'(pht_update_en), 32'(tbl[i].e_en));
         chk($sformatf("v%0d idx_up", i), 32'(pht_idx_up), 32'(tbl[i].e_idxup));
         if (tbl[i].e_en || tbl[i].rst)
            chk($sformatf("v%0d upd_val", i), 32'(pht_update_val), 32'(tbl[i].e_val));
         chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(tbl[i].e_mis));
         chk($sformatf("v%0d res_err", i), 32'(res_err), 32'(tbl[i].e_err));
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      // flush together with a correct resolve: GHR restores from the entry behind the head
      do_reset();
      for (int k = 0; k < 3; k++) begin
         pred_req = 1; pc_idx = '0; pht_read = 2'd2;
         @(posedge clk); #1;
      end
      pred_req = 0; res_valid = 1; res_taken = 1; flush = 1;
      @(posedge clk); #1;
      drive_idle();
      #3;
      chk("flushpop ghr", 32'(pht_idx), 32'h01);
      chk("flushpop upd_en", 32'(pht_update_en), 32'h1);
      chk("flushpop idx_up", 32'(pht_idx_up), 32'h00);
      chk("flushpop mispredict", 32'(mispredict), 32'h0);
      chk("flushpop ready", 32'(pred_ready), 32'h1);
      @(posedge clk); #1;

      // async reset between resolve and update
      do_reset();
      res_valid = 1;
      @(posedge clk); #1;
      res_valid = 0; pred_req = 1; pc_idx = 5'h05; pht_read = 2'd2;
      @(posedge clk); #1;
      pred_req = 0; res_valid = 1; res_taken = 1;
      @(posedge clk); #1;
      drive_idle(); pc_idx = 5'h09; pht_read_up = 2'd1;
      #1;
      chk("preRst err", 32'(res_err), 32'h1);
      chk("preRst upd_en", 32'(pht_update_en), 32'h1);
      chk("preRst idx_up", 32'(pht_idx_up), 32'h05);
      rst = 1'b1;
      #1;
      chk("asyncRst upd_en", 32'(pht_update_en), 32'h0);
      chk("asyncRst idx_up", 32'(pht_idx_up), 32'h0);
      chk("asyncRst upd_val", 32'(pht_update_val), 32'h0);
      chk("asyncRst ghr", 32'(pht_idx), 32'h09);
      chk("asyncRst ready", 32'(pred_ready), 32'h1);
      chk("asyncRst err", 32'(res_err), 32'h0);
      chk("asyncRst mispredict", 32'(mispredict), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // randomized run against the reference model
      do_reset();
      mq.delete();
      m_ghr = '0; m_upd = 0; m_upd_t = 0; m_upd_idx = '0; m_mis = 0; m_err = 0;
      foreach (pht[i]) pht[i] = CB'($urandom_range(0, CMAX));
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit [IB-1:0] e_idx;
         bit          e_pt, fire, pop, mis, nrv;
         int          e_val;
         ment_t       h;

         pc_idx    = IB'($urandom);
         pred_req  = ($urandom_range(0, 9) < 6);
         nrv       = ($urandom_range(0, 9) < 4);
         if (mq.size() == 0 && $urandom_range(0, 19) != 0) nrv = 0;
         res_valid = nrv;
         res_taken = 1'($urandom);
         flush     = ($urandom_range(0, 24) == 0);
         e_idx     = pc_idx ^ m_ghr;
         pht_read  = pht[e_idx];
         e_pt      = (int'(pht[e_idx]) >= (1 << (CB - 1)));
         pht_read_up = m_upd ? pht[m_upd_idx] : CB'($urandom_range(0, CMAX));
         e_val = m_upd ? sat_ref(int'(pht[m_upd_idx]), m_upd_t) : 0;
         #3;
         chk("rnd pht_idx", 32'(pht_idx), 32'(e_idx));
         chk("rnd pred_taken", 32'(pred_taken), 32'(e_pt));
         chk("rnd pred_ready", 32'(pred_ready), 32'(mq.size() < QD));
         chk("rnd upd_en", 32'(pht_update_en), 32'(m_upd));
         chk("rnd idx_up", 32'(pht_idx_up), 32'(m_upd_idx));
         if (m_upd) chk("rnd upd_val", 32'(pht_update_val), 32'(e_val));
         chk("rnd mispredict", 32'(mispredict), 32'(m_mis));
         chk("rnd res_err", 32'(res_err), 32'(m_err));

         if (m_upd) pht[m_upd_idx] = CB'(e_val);
         fire = pred_req && (mq.size() < QD);
         pop  = res_valid && (mq.size() > 0);
         mis  = pop && (res_taken != mq[0].pred);
         if (res_valid && mq.size() == 0) m_err = 1;
         m_upd = pop;
         if (pop) begin m_upd_idx = mq[0].idx; m_upd_t = res_taken; end
         m_mis = mis;
         if (mis) begin
            m_ghr = IB'((mq[0].ghr << 1) | res_taken);
            mq.delete();
         end else if (flush) begin
            if (pop) h = mq.pop_front();
            if (mq.size() > 0) m_ghr = mq[0].ghr;
            mq.delete();
         end else begin
            if (pop) h = mq.pop_front();
            if (fire) begin
               mq.push_back('{idx: e_idx, ghr: m_ghr, pred: e_pt});
               m_ghr = IB'((m_ghr << 1) | e_pt);
            end
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule

// File: doc/ama_riscv_bp_ctrl.md
Name: ama_riscv_bp_ctrl

Overview:
- Gshare branch-predictor controller; drives both PHT ports: the read index at fetch and the update write-back at resolve.
- Fetch side: per conditional branch, computes the PHT index from the PC and global history, and returns the taken/not-taken prediction.
- Tracks in-flight predictions in a small in-order queue.
- On resolution from EX: trains the saturating counter and detects mispredicts. On a mispredict it repairs the global history register (GHR) and flushes the wrong-path queue entries.

Parameters:
- IDX_BITS, 5, PHT index width; GHR width equals IDX_BITS.
- CNT_BITS, 2, PHT counter width.
- Q_DEPTH, 4, maximum in-flight predictions; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pred_req  in  1  fetch requests a prediction for a conditional branch
- pc_idx  in  IDX_BITS  pre-sliced PC bits
- pred_ready  out  1  queue not full
- pred_taken  out  1  prediction, combinational
- pht_idx  out  IDX_BITS  to PHT read index
- pht_read  in  CNT_BITS  PHT counter at pht_idx
- res_valid  in  1  oldest branch resolved, in program order
- res_taken  in  1  actual outcome
- flush  in  1  external pipeline flush (trap/jalr redirect)
- pht_idx_up  out  IDX_BITS  PHT update index
- pht_read_up  in  CNT_BITS  PHT counter at pht_idx_up
- pht_update_val  out  CNT_BITS  new counter value
- pht_update_en  out  1  PHT write enable
- mispredict  out  1  one-cycle pulse, registered
- res_err  out  1  sticky: res_valid arrived with the queue empty

Behaviour:
- Reset values: GHR=0; queue empty (count=0); pred_ready=1; pht_update_en=0; pht_idx_up=0; pht_update_val=0; mispredict=0; res_err=0. The same values apply if rst asserts mid-operation; any pending update is discarded.
- pht_idx = pc_idx XOR GHR (combinational).
- pred_taken = pht_read[CNT_BITS-1].
- Fire = pred_req && pred_ready.
  - On fire, push {idx=pht_idx, ghr=GHR, pred=pred_taken}.
  - On fire, GHR <= {GHR[IDX_BITS-2:0], pred_taken}.
- pred_ready = (count != Q_DEPTH). There is no same-cycle pop bypass, so a full queue stalls fetch for one cycle even if a resolve pops in that cycle.
- On res_valid with the queue non-empty, pop the head into the update register {idx, taken=res_taken}.
- Update stage, 1-cycle latency:
  - In the cycle after the resolve, pht_update_en=1 and pht_idx_up = the registered idx.
  - pht_update_val = the counter saturating-incremented if taken, saturating-decremented if not taken, computed from pht_read_up.
  - Saturation bounds are 0 and 2^CNT_BITS-1.
  - In all other cycles pht_update_en=0.
- Mispredict: res_valid && (res_taken != head.pred). Next cycle:
  - mispredict=1.
  - GHR <= {head.ghr[IDX_BITS-2:0], res_taken}.
  - Queue cleared (count=0); all younger entries are wrong-path.
  - The update to the head entry still occurs.
- Flush without mispredict:
  - Queue cleared.
  - GHR <= head.ghr if the queue is non-empty (drops all speculative history); otherwise GHR is unchanged.
  - A same-cycle correct resolve still trains the PHT, and the GHR restores from the post-pop head; if none remains, GHR is unchanged.
- Priority: rst > mispredict > flush > fire. Same-cycle fire is dropped on mispredict or flush.
- Simultaneous fire and correct resolve: push and pop both occur; count is unchanged.
- res_valid on an empty queue: ignored (no update, no mispredict); res_err is set and stays set until reset.
- No forwarding: a prediction reading an index being updated that same cycle sees the old counter value.
- Queue pointers wrap modulo Q_DEPTH; count is clog2(Q_DEPTH)+1 bits wide.

Decomposition:
- Package ama_riscv_bp_pkg holds:
  - typedefs bp_idx_t and bp_cnt_t
  - struct bp_q_entry_t {idx, ghr, pred}
  - function sat_cnt(cnt, taken)
- Sub-module ama_riscv_bp_queue:
  - synchronous FIFO of bp_q_entry_t with push, pop and clear
  - head output and count
  - asynchronous reset

Test Plan:
- Predict/train: GHR=0, pc_idx=5'h0A, pht_read=2 -> pht_idx=0x0A, pred_taken=1, GHR=5'b00001 after fire. Then res_taken=1 -> next cycle pht_update_en=1, pht_idx_up=0x0A, with pht_read_up=2 -> pht_update_val=3.
- Saturation: pht_read_up=3 with resolve taken -> pht_update_val=3. pht_read_up=0 with resolve not-taken -> pht_update_val=0.
- Mispredict repair: three fires predicting taken from GHR=0 (GHR becomes 5'b00111). Resolve the first with res_taken=0 -> mispredict pulse 1 cycle, count=0, GHR=5'b00000, update at the first entry's idx.
- Full/stall: with Q_DEPTH=4, 4 fires -> pred_ready=0. pred_req held while resolve pops -> no push that cycle. The next cycle pred_ready=1 and the push completes.
- Simultaneous events and errors:
  - Flush with 2 entries pending -> GHR restored to the oldest snapshot, count=0.
  - res_valid on empty -> res_err=1, pht_update_en stays 0.
- Async reset mid-update: assert rst between resolve and update -> pht_update_en=0 immediately, GHR=0, pred_ready=1.
